// File: rtl/pwm_scan_ctrl.sv
// Round-robin RC PWM width scanner: one shared width counter, per-channel bank, loss flags, auto/manual mode.
// Optional macro PWM_SCAN_FAILSAFE_EN: a timed-out channel's bank entry is overwritten with FAILSAFE_VAL.
module pwm_scan_ctrl #(
  parameter int          NCH          = 4,
  parameter logic [15:0] TIMEOUT      = 16'd2000,
  parameter int          MODE_CH      = 3,
  parameter logic [7:0]  MODE_THR     = 8'd150,
  parameter logic [7:0]  FAILSAFE_VAL = 8'd128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           scan_en,
  input  logic [NCH-1:0] pul_in,
  input  logic [2:0]     rd_addr,
  output logic [7:0]     rd_data,
  output logic [NCH-1:0] lost,
  output logic [2:0]     cur_ch,
  output logic           frame_done,
  output logic           mode_auto
);

`ifdef PWM_SCAN_FAILSAFE_EN
  localparam logic FS_WRITE = 1'b1;
`else
  localparam logic FS_WRITE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, MEASURE, STORE, NEXT} state_t;

  state_t           state;
  logic [NCH-1:0]   pul_p0;
  logic [NCH-1:0]   pul_p1;
  logic             prv;
  logic             cur;
  logic             nxt_lvl;
  logic [2:0]       nxt_ch;
  logic             wrap;
  logic             in_slot;
  logic             tmo_hit;
  logic [7:0]       width;
  logic [15:0]      tmo_cnt;
  logic [7:0]       bank [NCH];
  logic             mode_upd;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer on every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pul_p0 <= '0;
      pul_p1 <= '0;
    end else begin
      pul_p0 <= pul_in;
      pul_p1 <= pul_p0;
    end
  end

  always_comb begin
    wrap    = (cur_ch == 3'(NCH - 1));
    nxt_ch  = wrap ? 3'd0 : cur_ch + 3'd1;
    cur     = 1'b0;
    nxt_lvl = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_ch == 3'(i)) cur = pul_p1[i];
      if (nxt_ch == 3'(i)) nxt_lvl = pul_p1[i];
    end
    in_slot = (state == ARM) || (state == WAIT_RISE) || (state == MEASURE);
    tmo_hit = in_slot && (tmo_cnt == TIMEOUT);
  end

  // Scan FSM: owns channel pointer, width/timeout counters, bank and loss flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_ch     <= 3'd0;
      prv        <= 1'b0;
      width      <= 8'd0;
      tmo_cnt    <= 16'd0;
      lost       <= '1;
      frame_done <= 1'b0;
      mode_upd   <= 1'b0;
      for (int i = 0; i < NCH; i++) bank[i] <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      mode_upd   <= 1'b0;
      prv        <= cur;
      if (!scan_en) begin
        state <= IDLE;
      end else if (tmo_hit) begin
        for (int i = 0; i < NCH; i++) begin
          if (cur_ch == 3'(i)) begin
            lost[i] <= 1'b1;
            if (FS_WRITE) bank[i] <= FAILSAFE_VAL;
          end
        end
        mode_upd <= (cur_ch == 3'(MODE_CH));
        state    <= NEXT;
      end else begin
        if (in_slot && tick) tmo_cnt <= tmo_cnt + 16'd1;
        case (state)
          IDLE: begin
            tmo_cnt <= 16'd0;
            state   <= ARM;
          end
          ARM: begin
            // Never start on a pulse that is already high
            if (!cur) state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (!prv && cur) begin
              width <= 8'd0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (prv && !cur) state <= STORE;
            else if (tick && cur) width <= sat_inc(width);
          end
          STORE: begin
            for (int i = 0; i < NCH; i++) begin
              if (cur_ch == 3'(i)) begin
                bank[i] <= width;
                lost[i] <= 1'b0;
              end
            end
            mode_upd <= (cur_ch == 3'(MODE_CH));
            state    <= NEXT;
          end
          NEXT: begin
            // Edge history restarts from the new channel's current level
            cur_ch     <= nxt_ch;
            width      <= 8'd0;
            prv        <= nxt_lvl;
            tmo_cnt    <= 16'd0;
            frame_done <= wrap;
            state      <= ARM;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Registered read port and mode decision, one cycle behind bank updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= 8'd0;
      mode_auto <= 1'b0;
    end else begin
      rd_data <= 8'd0;
      for (int i = 0; i < NCH; i++) begin
        if (rd_addr == 3'(i)) rd_data <= bank[i];
      end
      if (mode_upd) mode_auto <= (bank[MODE_CH] > MODE_THR) && !lost[MODE_CH];
    end
  end

endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// Directed bench for pwm_scan_ctrl; expected bank values follow PWM_SCAN_FAILSAFE_EN when defined.
module tb_pwm_scan_ctrl;
  localparam int NCH = 4;

`ifdef PWM_SCAN_FAILSAFE_EN
  localparam logic [7:0] LOST1_BANK = 8'd128;
  localparam logic [7:0] LOST3_BANK = 8'd128;
`else
  localparam logic [7:0] LOST1_BANK = 8'd100;
  localparam logic [7:0] LOST3_BANK = 8'd160;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick;
  logic           scan_en;
  logic [NCH-1:0] pul_in;
  logic [2:0]     rd_addr;
  logic [7:0]     rd_data;
  logic [NCH-1:0] lost;
  logic [2:0]     cur_ch;
  logic           frame_done;
  logic           mode_auto;

  int   total = 0;
  int   bad   = 0;
  int   hi   [NCH];
  int   per  [NCH];
  int   gcnt [NCH];
  logic md   [NCH];
  logic lvl  [NCH];

  always #5 clk = ~clk;

  pwm_scan_ctrl #(
    .NCH(NCH), .TIMEOUT(16'd2000), .MODE_CH(3), .MODE_THR(8'd150), .FAILSAFE_VAL(8'd128)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .scan_en(scan_en), .pul_in(pul_in),
    .rd_addr(rd_addr), .rd_data(rd_data), .lost(lost), .cur_ch(cur_ch),
    .frame_done(frame_done), .mode_auto(mode_auto)
  );

  // Pulse source: periodic (high for hi cycles out of per) or manual level when md=1
  initial begin
    pul_in = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        gcnt[c]   = (gcnt[c] + 1 >= per[c]) ? 0 : gcnt[c] + 1;
        pul_in[c] = md[c] ? lvl[c] : (gcnt[c] < hi[c]);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    rd_addr = a;
    @(posedge clk);
    #1 d = rd_data;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ch(input logic [2:0] c, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (cur_ch == c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; scan_en = 1'b0; tick = 1'b1; rd_addr = 3'd0;
    cyc(3);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%0h want=0", rd_data); end
    total++; if (lost !== 4'hF) begin bad++; $display("FAIL reset_lost got=%0h want=f", lost); end
    total++; if (cur_ch !== 3'd0) begin bad++; $display("FAIL reset_cur_ch got=%0d want=0", cur_ch); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0b want=0", frame_done); end
    total++; if (mode_auto !== 1'b0) begin bad++; $display("FAIL reset_mode_auto got=%0b want=0", mode_auto); end
    rst_n = 1'b1;
    cyc(20);
    total++; if (cur_ch !== 3'd0 || lost !== 4'hF) begin bad++; $display("FAIL idle_hold cur_ch=%0d lost=%0h want 0/f", cur_ch, lost); end
  endtask

  // Rise-detect cycle is not counted: H synchronized high cycles give width H-1
  task automatic test_frame;
    bit ok;
    logic [7:0] d;
    scan_en = 1'b1;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL frame_timeout got=no_frame_done want=frame_done"); end
    total++; if (cur_ch !== 3'd0) begin bad++; $display("FAIL frame_wrap_ch got=%0d want=0", cur_ch); end
    cyc(1);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_pulse_len got=%0b want=0", frame_done); end
    for (int c = 0; c < NCH; c++) begin
      rd(3'(c), d);
      total++; if (d !== 8'd100) begin bad++; $display("FAIL frame_bank%0d got=%0d want=100", c, d); end
    end
    total++; if (lost !== 4'h0) begin bad++; $display("FAIL frame_lost got=%0h want=0", lost); end
    total++; if (mode_auto !== 1'b0) begin bad++; $display("FAIL frame_mode got=%0b want=0", mode_auto); end
    rd(3'd5, d);
    total++; if (d !== 8'd0) begin bad++; $display("FAIL rd_oob5 got=%0d want=0", d); end
    rd(3'd7, d);
    total++; if (d !== 8'd0) begin bad++; $display("FAIL rd_oob7 got=%0d want=0", d); end
  endtask

  task automatic test_saturate;
    bit ok;
    logic [7:0] d;
    wait_frame(ok);
    hi[2] = 401; per[2] = 700;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=no_frame_done want=frame_done"); end
    rd(3'd2, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL sat_bank2 got=%0d want=255", d); end
    total++; if (lost[2] !== 1'b0) begin bad++; $display("FAIL sat_lost2 got=%0b want=0", lost[2]); end
    hi[2] = 101; per[2] = 300;
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    logic [7:0] d;
    wait_frame(ok);
    md[1] = 1'b1; lvl[1] = 1'b0;
    wait_ch(3'd1, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_reach_ch1 got=cur_ch%0d want=1", cur_ch); end
    n = 0;
    for (int i = 1; i <= 2100; i++) begin
      @(posedge clk);
      #1;
      if (lost[1]) begin
        n = i;
        break;
      end
    end
    total++; if (n != 2001) begin bad++; $display("FAIL tmo_latency got=%0d want=2001", n); end
    cyc(1);
    total++; if (cur_ch !== 3'd2) begin bad++; $display("FAIL tmo_advance got=%0d want=2", cur_ch); end
    rd(3'd1, d);
    total++; if (d !== LOST1_BANK) begin bad++; $display("FAIL tmo_bank1 got=%0d want=%0d", d, LOST1_BANK); end
    md[1] = 1'b0;
    wait_frame(ok);
    wait_frame(ok);
    total++; if (lost !== 4'h0) begin bad++; $display("FAIL tmo_recover_lost got=%0h want=0", lost); end
    rd(3'd1, d);
    total++; if (d !== 8'd100) begin bad++; $display("FAIL tmo_recover_bank1 got=%0d want=100", d); end
  endtask

  task automatic test_mode;
    bit ok;
    logic [7:0] d;
    hi[3] = 161;
    wait_frame(ok);
    total++; if (mode_auto !== 1'b1) begin bad++; $display("FAIL mode_160 got=%0b want=1", mode_auto); end
    hi[3] = 141;
    wait_frame(ok);
    total++; if (mode_auto !== 1'b0) begin bad++; $display("FAIL mode_140 got=%0b want=0", mode_auto); end
    rd(3'd3, d);
    total++; if (d !== 8'd140) begin bad++; $display("FAIL mode_bank3 got=%0d want=140", d); end
    hi[3] = 161;
    wait_frame(ok);
    total++; if (mode_auto !== 1'b1) begin bad++; $display("FAIL mode_160b got=%0b want=1", mode_auto); end
    md[3] = 1'b1; lvl[3] = 1'b0;
    wait_frame(ok);
    total++; if (lost[3] !== 1'b1) begin bad++; $display("FAIL mode_lost3 got=%0b want=1", lost[3]); end
    total++; if (mode_auto !== 1'b0) begin bad++; $display("FAIL mode_lost_manual got=%0b want=0", mode_auto); end
    rd(3'd3, d);
    total++; if (d !== LOST3_BANK) begin bad++; $display("FAIL mode_lost_bank3 got=%0d want=%0d", d, LOST3_BANK); end
    md[3] = 1'b0; hi[3] = 101;
    wait_frame(ok);
    total++; if (lost !== 4'h0 || mode_auto !== 1'b0) begin bad++; $display("FAIL mode_restore lost=%0h mode=%0b want 0/0", lost, mode_auto); end
  endtask

  task automatic test_armed_high;
    bit ok;
    logic [7:0] d;
    wait_frame(ok);
    scan_en = 1'b0; md[0] = 1'b1; lvl[0] = 1'b1;
    cyc(5);
    scan_en = 1'b1;
    cyc(50);
    total++; if (cur_ch !== 3'd0) begin bad++; $display("FAIL armed_hold_ch got=%0d want=0", cur_ch); end
    rd(3'd0, d);
    total++; if (d !== 8'd100) begin bad++; $display("FAIL armed_no_store got=%0d want=100", d); end
    lvl[0] = 1'b0;
    cyc(20);
    lvl[0] = 1'b1;
    cyc(61);
    lvl[0] = 1'b0;
    wait_ch(3'd1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL armed_advance got=cur_ch%0d want=1", cur_ch); end
    rd(3'd0, d);
    total++; if (d !== 8'd60) begin bad++; $display("FAIL armed_width got=%0d want=60", d); end
  endtask

  task automatic test_scan_drop;
    bit ok;
    logic [7:0] d;
    wait_frame(ok);
    cyc(10);
    lvl[0] = 1'b1;
    cyc(30);
    scan_en = 1'b0;
    cyc(2);
    lvl[0] = 1'b0;
    cyc(20);
    total++; if (cur_ch !== 3'd0) begin bad++; $display("FAIL drop_ch got=%0d want=0", cur_ch); end
    total++; if (lost !== 4'h0) begin bad++; $display("FAIL drop_lost got=%0h want=0", lost); end
    rd(3'd0, d);
    total++; if (d !== 8'd60) begin bad++; $display("FAIL drop_bank0 got=%0d want=60", d); end
  endtask

  task automatic test_back_to_back_read;
    scan_en = 1'b1; rd_addr = 3'd0;
    cyc(10);
    lvl[0] = 1'b1;
    cyc(41);
    lvl[0] = 1'b0;
    cyc(4);
    total++; if (rd_data !== 8'd60) begin bad++; $display("FAIL rd_same_cycle got=%0d want=60", rd_data); end
    cyc(1);
    total++; if (rd_data !== 8'd40) begin bad++; $display("FAIL rd_next_cycle got=%0d want=40", rd_data); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    md[1] = 1'b1; lvl[1] = 1'b0;
    cyc(12);
    lvl[1] = 1'b1;
    cyc(30);
    total++; if (cur_ch !== 3'd1) begin bad++; $display("FAIL rstmid_pre_ch got=%0d want=1", cur_ch); end
    rst_n = 1'b0;
    #1;
    total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL rstmid_rd_data got=%0d want=0", rd_data); end
    total++; if (lost !== 4'hF) begin bad++; $display("FAIL rstmid_lost got=%0h want=f", lost); end
    total++; if (cur_ch !== 3'd0) begin bad++; $display("FAIL rstmid_ch got=%0d want=0", cur_ch); end
    total++; if (frame_done !== 1'b0 || mode_auto !== 1'b0) begin bad++; $display("FAIL rstmid_flags fd=%0b mode=%0b want 0/0", frame_done, mode_auto); end
    cyc(2);
    scan_en = 1'b0; rst_n = 1'b1;
    cyc(2);
    for (int c = 0; c < NCH; c++) begin
      rd(3'(c), d);
      total++; if (d !== 8'd0) begin bad++; $display("FAIL rstmid_bank%0d got=%0d want=0", c, d); end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      hi[c] = 101; per[c] = 300; gcnt[c] = c * 70; md[c] = 1'b0; lvl[c] = 1'b0;
    end
    rst_n = 1'b0; scan_en = 1'b0; tick = 1'b1; rd_addr = 3'd0;
    @(posedge clk);
    #1;
    test_reset;
    test_frame;
    test_saturate;
    test_timeout;
    test_mode;
    test_armed_high;
    test_scan_drop;
    test_back_to_back_read;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
